unit_control_decode: RTL and testbench

UNIT_CONTROL_DECODE -- requirements
Module: unit_control_decode

---
 rtl/unit_control_decode_pkg.sv | 114 +++++++++++
 rtl/unit_control_decode_if.sv | 38 +++
 rtl/unit_control_decode_imm_gen.sv | 26 ++
 rtl/unit_control_decode.sv | 214 +++++++++++++++++++++
 tb/tb_unit_control_decode.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/unit_control_decode_pkg.sv
// Shared definitions for the RV32 control decoder: ALU operation codes,
// major opcodes, funct7 patterns, immediate formats and the decoded bundle.
package unit_control_decode_pkg;

  // ALU operation codes
  localparam logic [5:0] ALU_ADD    = 6'b000000;
  localparam logic [5:0] ALU_SLL    = 6'b000001;
  localparam logic [5:0] ALU_SLT    = 6'b000010;
  localparam logic [5:0] ALU_SLTU   = 6'b000011;
  localparam logic [5:0] ALU_XOR    = 6'b000100;
  localparam logic [5:0] ALU_SRL    = 6'b000101;
  localparam logic [5:0] ALU_OR     = 6'b000110;
  localparam logic [5:0] ALU_AND    = 6'b000111;
  localparam logic [5:0] ALU_MUL    = 6'b001000;
  localparam logic [5:0] ALU_MULH   = 6'b001001;
  localparam logic [5:0] ALU_MULHSU = 6'b001010;
  localparam logic [5:0] ALU_MULHU  = 6'b001011;
  localparam logic [5:0] ALU_DIV    = 6'b001100;
  localparam logic [5:0] ALU_DIVU   = 6'b001101;
  localparam logic [5:0] ALU_REM    = 6'b001110;
  localparam logic [5:0] ALU_REMU   = 6'b001111;
  localparam logic [5:0] ALU_SUB    = 6'b010000;
  localparam logic [5:0] ALU_SRA    = 6'b010101;
  localparam logic [5:0] ALU_FWD    = 6'b011000;

  // Major opcodes (bits [6:0])
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // funct7 patterns
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  typedef enum logic [2:0] {
    IMM_I    = 3'd0,
    IMM_S    = 3'd1,
    IMM_B    = 3'd2,
    IMM_U    = 3'd3,
    IMM_J    = 3'd4,
    IMM_NONE = 3'd5
  } imm_type_e;

  typedef struct packed {
    logic [5:0]  alu_select;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic        op_a_pc;
    logic        op_b_imm;
    logic        reg_write_en;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        illegal;
  } bundle_t;

  // Base integer ALU op selected by funct3 (funct7 = 0000000 forms)
  function automatic logic [5:0] base_alu(input logic [2:0] f3);
    logic [5:0] op;
    case (f3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  // Multiply/divide op selected by funct3 (funct7 = 0000001 forms)
  function automatic logic [5:0] mext_alu(input logic [2:0] f3);
    logic [5:0] op;
    case (f3)
      3'b000:  op = ALU_MUL;
      3'b001:  op = ALU_MULH;
      3'b010:  op = ALU_MULHSU;
      3'b011:  op = ALU_MULHU;
      3'b100:  op = ALU_DIV;
      3'b101:  op = ALU_DIVU;
      3'b110:  op = ALU_REM;
      3'b111:  op = ALU_REMU;
      default: op = ALU_MUL;
    endcase
    return op;
  endfunction

  // Compare operation a branch needs; funct3 01x has no branch meaning
  function automatic logic [5:0] branch_alu(input logic [2:0] f3);
    logic [5:0] op;
    case (f3[2:1])
      2'b00:   op = ALU_SUB;
      2'b10:   op = ALU_SLT;
      2'b11:   op = ALU_SLTU;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/unit_control_decode_if.sv
// Handshake and decoded-bundle signals of the control decoder.
// master = instruction source / bundle consumer, slave = the decoder.
interface unit_control_decode_if;
  logic [31:0] in_instr;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  alu_select;
  logic [31:0] imm;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        op_a_pc;
  logic        op_b_imm;
  logic        reg_write_en;
  logic        mem_read;
  logic        mem_write;
  logic        branch;
  logic        jump;
  logic [2:0]  funct3_out;
  logic        illegal;

  modport master (
    output in_instr, in_valid, flush, out_ready,
    input  in_ready, out_valid, alu_select, imm, rd, rs1, rs2,
           op_a_pc, op_b_imm, reg_write_en, mem_read, mem_write,
           branch, jump, funct3_out, illegal
  );

  modport slave (
    input  in_instr, in_valid, flush, out_ready,
    output in_ready, out_valid, alu_select, imm, rd, rs1, rs2,
           op_a_pc, op_b_imm, reg_write_en, mem_read, mem_write,
           branch, jump, funct3_out, illegal
  );
endinterface

// File: rtl/unit_control_decode_imm_gen.sv
// Immediate generator: reassembles and sign-extends the immediate of the
// given RV32 format. Opcode bits [6:0] never carry immediate data.
module unit_control_decode_imm_gen
  import unit_control_decode_pkg::*;
(
  input  logic [31:7] instr,
  input  imm_type_e   imm_type,
  output logic [31:0] imm
);

  // Select the bit-scatter pattern of the requested immediate format
  always_comb begin
    case (imm_type)
      IMM_I:    imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:    imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:    imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                       instr[11:8], 1'b0};
      IMM_U:    imm = {instr[31:12], 12'h000};
      IMM_J:    imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                       instr[30:21], 1'b0};
      IMM_NONE: imm = 32'h0000_0000;
      default:  imm = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/unit_control_decode.sv
// RV32I(+M) control decoder with a single-entry registered output stage.
// An accepted instruction appears decoded one cycle later; the bundle is
// held until consumed. Unsupported encodings still produce a bundle with
// ILLEGAL set so the trap can be raised downstream.
module unit_control_decode
  import unit_control_decode_pkg::*;
#(
  parameter bit M_EXT_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  unit_control_decode_if.slave bus
);

  logic [6:0]  opcode_s;
  logic [2:0]  funct3_s;
  logic [6:0]  funct7_s;
  logic        legal_s;
  imm_type_e   imm_type_s;
  bundle_t     dec_s;
  logic [31:0] gen_imm_s;
  logic        in_ready_s;
  logic        accept_s;

  logic        out_valid_d;
  logic        out_valid_q;
  bundle_t     bundle_d;
  bundle_t     bundle_q;

  assign opcode_s = bus.in_instr[6:0];
  assign funct3_s = bus.in_instr[14:12];
  assign funct7_s = bus.in_instr[31:25];

  // A flush blocks acceptance so the incoming word is dropped with the held one
  assign in_ready_s = !bus.flush && (!out_valid_q || bus.out_ready);
  assign accept_s   = bus.in_valid && in_ready_s;

  unit_control_decode_imm_gen u_imm_gen (
    .instr    (bus.in_instr[31:7]),
    .imm_type (imm_type_s),
    .imm      (gen_imm_s)
  );

  // Decode the incoming word into control strobes, ALU op and immediate format
  always_comb begin
    dec_s      = '0;
    imm_type_s = IMM_NONE;
    legal_s    = 1'b0;
    case (opcode_s)
      OPC_OP: begin
        dec_s.reg_write_en = 1'b1;
        if (funct7_s == F7_BASE) begin
          legal_s          = 1'b1;
          dec_s.alu_select = base_alu(funct3_s);
        end else if ((funct7_s == F7_ALT) && (funct3_s == 3'b000)) begin
          legal_s          = 1'b1;
          dec_s.alu_select = ALU_SUB;
        end else if ((funct7_s == F7_ALT) && (funct3_s == 3'b101)) begin
          legal_s          = 1'b1;
          dec_s.alu_select = ALU_SRA;
        end else if ((funct7_s == F7_MEXT) && (M_EXT_EN == 1'b1)) begin
          legal_s          = 1'b1;
          dec_s.alu_select = mext_alu(funct3_s);
        end else begin
          legal_s = 1'b0;
        end
      end
      OPC_OP_IMM: begin
        dec_s.op_b_imm     = 1'b1;
        dec_s.reg_write_en = 1'b1;
        imm_type_s         = IMM_I;
        if (funct3_s == 3'b001) begin
          legal_s          = (funct7_s == F7_BASE);
          dec_s.alu_select = ALU_SLL;
        end else if (funct3_s == 3'b101) begin
          if (funct7_s == F7_BASE) begin
            legal_s          = 1'b1;
            dec_s.alu_select = ALU_SRL;
          end else if (funct7_s == F7_ALT) begin
            legal_s          = 1'b1;
            dec_s.alu_select = ALU_SRA;
          end else begin
            legal_s = 1'b0;
          end
        end else begin
          legal_s          = 1'b1;
          dec_s.alu_select = base_alu(funct3_s);
        end
      end
      OPC_LOAD: begin
        dec_s.alu_select   = ALU_ADD;
        dec_s.op_b_imm     = 1'b1;
        dec_s.mem_read     = 1'b1;
        dec_s.reg_write_en = 1'b1;
        imm_type_s         = IMM_I;
        case (funct3_s)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_s = 1'b1;
          default:                                legal_s = 1'b0;
        endcase
      end
      OPC_STORE: begin
        dec_s.alu_select = ALU_ADD;
        dec_s.op_b_imm   = 1'b1;
        dec_s.mem_write  = 1'b1;
        imm_type_s       = IMM_S;
        case (funct3_s)
          3'b000, 3'b001, 3'b010: legal_s = 1'b1;
          default:                legal_s = 1'b0;
        endcase
      end
      OPC_BRANCH: begin
        dec_s.branch     = 1'b1;
        dec_s.alu_select = branch_alu(funct3_s);
        imm_type_s       = IMM_B;
        legal_s          = (funct3_s[2:1] != 2'b01);
      end
      OPC_LUI: begin
        legal_s            = 1'b1;
        dec_s.alu_select   = ALU_FWD;
        dec_s.op_b_imm     = 1'b1;
        dec_s.reg_write_en = 1'b1;
        imm_type_s         = IMM_U;
      end
      OPC_AUIPC: begin
        legal_s            = 1'b1;
        dec_s.alu_select   = ALU_ADD;
        dec_s.op_a_pc      = 1'b1;
        dec_s.op_b_imm     = 1'b1;
        dec_s.reg_write_en = 1'b1;
        imm_type_s         = IMM_U;
      end
      OPC_JAL: begin
        legal_s            = 1'b1;
        dec_s.alu_select   = ALU_ADD;
        dec_s.op_a_pc      = 1'b1;
        dec_s.op_b_imm     = 1'b1;
        dec_s.jump         = 1'b1;
        dec_s.reg_write_en = 1'b1;
        imm_type_s         = IMM_J;
      end
      OPC_JALR: begin
        legal_s            = (funct3_s == 3'b000);
        dec_s.alu_select   = ALU_ADD;
        dec_s.op_b_imm     = 1'b1;
        dec_s.jump         = 1'b1;
        dec_s.reg_write_en = 1'b1;
        imm_type_s         = IMM_I;
      end
      default: begin
        legal_s = 1'b0;
      end
    endcase

    // Illegal words keep only the ILLEGAL flag; field passthrough still applies
    if (legal_s && (bus.in_instr[1:0] == 2'b11)) begin
      dec_s.illegal = 1'b0;
    end else begin
      dec_s         = '0;
      imm_type_s    = IMM_NONE;
      dec_s.illegal = 1'b1;
    end

    dec_s.rd     = bus.in_instr[11:7];
    dec_s.rs1    = bus.in_instr[19:15];
    dec_s.rs2    = bus.in_instr[24:20];
    dec_s.funct3 = funct3_s;
  end

  // Output-stage next state: flush drops, accept loads, consume empties
  always_comb begin
    out_valid_d = out_valid_q;
    bundle_d    = bundle_q;
    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (accept_s) begin
      out_valid_d  = 1'b1;
      bundle_d     = dec_s;
      bundle_d.imm = gen_imm_s;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Output register with synchronous reset clearing the whole bundle
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      bundle_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      bundle_q    <= bundle_d;
    end
  end

  assign bus.in_ready     = in_ready_s;
  assign bus.out_valid    = out_valid_q;
  assign bus.alu_select   = bundle_q.alu_select;
  assign bus.imm          = bundle_q.imm;
  assign bus.rd           = bundle_q.rd;
  assign bus.rs1          = bundle_q.rs1;
  assign bus.rs2          = bundle_q.rs2;
  assign bus.op_a_pc      = bundle_q.op_a_pc;
  assign bus.op_b_imm     = bundle_q.op_b_imm;
  assign bus.reg_write_en = bundle_q.reg_write_en;
  assign bus.mem_read     = bundle_q.mem_read;
  assign bus.mem_write    = bundle_q.mem_write;
  assign bus.branch       = bundle_q.branch;
  assign bus.jump         = bundle_q.jump;
  assign bus.funct3_out   = bundle_q.funct3;
  assign bus.illegal      = bundle_q.illegal;

endmodule

// File: tb/tb_unit_control_decode.sv
// Bench for unit_control_decode: a directed vector table, hand-written
// stall/flush/reset sequences, and randomized traffic compared against an
// arithmetic reference decoder. Two instances run side by side, one with
// the M extension enabled and one without.
module tb_unit_control_decode;

  localparam logic [7:0] F_APC  = 8'h80;
  localparam logic [7:0] F_BIMM = 8'h40;
  localparam logic [7:0] F_WE   = 8'h20;
  localparam logic [7:0] F_MRD  = 8'h10;
  localparam logic [7:0] F_MWR  = 8'h08;
  localparam logic [7:0] F_BR   = 8'h04;
  localparam logic [7:0] F_JMP  = 8'h02;
  localparam logic [7:0] F_ILL  = 8'h01;

  typedef struct packed {
    logic [5:0]  alu;
    logic [31:0] imm;
    logic [7:0]  fl;
  } exp_t;

  typedef struct {
    logic [31:0] ins;
    exp_t        e;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  unit_control_decode_if bus1 ();
  unit_control_decode_if bus0 ();

  assign bus0.in_instr  = bus1.in_instr;
  assign bus0.in_valid  = bus1.in_valid;
  assign bus0.flush     = bus1.flush;
  assign bus0.out_ready = bus1.out_ready;

  unit_control_decode #(.M_EXT_EN(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  unit_control_decode #(.M_EXT_EN(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end else begin
      passed++;
    end
  endtask

  // Reference decoder: immediates as signed sums, ALU codes as numbers
  function automatic exp_t ref_decode(input logic [31:0] ins, input bit m_en);
    exp_t       e;
    int         alu;
    int         imm;
    int         sgn11;
    logic [7:0] fl;
    bit         ok;
    logic [2:0] f3;
    logic [6:0] f7;
    f3    = ins[14:12];
    f7    = ins[31:25];
    sgn11 = ins[31] ? -2048 : 0;
    alu   = 0;
    imm   = 0;
    fl    = 8'h00;
    ok    = 1'b1;
    case (ins[6:0])
      7'h33: begin
        fl = F_WE;
        if (f7 == 7'h00) alu = int'(f3);
        else if (f7 == 7'h20 && f3 == 3'd0) alu = 16;
        else if (f7 == 7'h20 && f3 == 3'd5) alu = 21;
        else if (f7 == 7'h01 && m_en) alu = 8 + int'(f3);
        else ok = 1'b0;
      end
      7'h13: begin
        fl  = F_BIMM | F_WE;
        imm = sgn11 + int'(ins[30:20]);
        if (f3 == 3'd1) begin
          ok  = (f7 == 7'h00);
          alu = 1;
        end else if (f3 == 3'd5) begin
          if (f7 == 7'h00) alu = 5;
          else if (f7 == 7'h20) alu = 21;
          else ok = 1'b0;
        end else begin
          alu = int'(f3);
        end
      end
      7'h03: begin
        fl  = F_BIMM | F_MRD | F_WE;
        imm = sgn11 + int'(ins[30:20]);
        ok  = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      end
      7'h23: begin
        fl  = F_BIMM | F_MWR;
        imm = sgn11 + int'(ins[30:25]) * 32 + int'(ins[11:7]);
        ok  = (f3 <= 3'd2);
      end
      7'h63: begin
        fl  = F_BR;
        imm = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32
              + int'(ins[11:8]) * 2;
        if (f3 <= 3'd1) alu = 16;
        else if (f3 == 3'd4 || f3 == 3'd5) alu = 2;
        else if (f3 >= 3'd6) alu = 3;
        else ok = 1'b0;
      end
      7'h37: begin
        fl  = F_BIMM | F_WE;
        alu = 24;
        imm = int'(ins[31:12]) * 4096;
      end
      7'h17: begin
        fl  = F_APC | F_BIMM | F_WE;
        imm = int'(ins[31:12]) * 4096;
      end
      7'h6F: begin
        fl  = F_APC | F_BIMM | F_JMP | F_WE;
        imm = (ins[31] ? -1048576 : 0) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
              + int'(ins[30:21]) * 2;
      end
      7'h67: begin
        fl  = F_BIMM | F_JMP | F_WE;
        imm = sgn11 + int'(ins[30:20]);
        ok  = (f3 == 3'd0);
      end
      default: ok = 1'b0;
    endcase
    if (!ok || ins[1:0] != 2'b11) begin
      alu = 0;
      imm = 0;
      fl  = F_ILL;
    end
    e.alu = alu[5:0];
    e.imm = imm;
    e.fl  = fl;
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 10))
      0: w[6:0] = 7'h33;
      1: w[6:0] = 7'h13;
      2: w[6:0] = 7'h03;
      3: w[6:0] = 7'h23;
      4: w[6:0] = 7'h63;
      5: w[6:0] = 7'h37;
      6: w[6:0] = 7'h17;
      7: w[6:0] = 7'h6F;
      8: w[6:0] = 7'h67;
      9: w[6:0] = 7'h33;
      default: w[6:0] = w[6:0];
    endcase
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      2: w[31:25] = 7'h01;
      default: w[31:25] = w[31:25];
    endcase
    return w;
  endfunction

  task automatic check_bundle(input string tag, input bit which, input logic [31:0] ins,
                              input exp_t e);
    logic [5:0]  a;
    logic [31:0] im;
    logic [7:0]  fl;
    logic [4:0]  rd, r1, r2;
    logic [2:0]  f3;
    if (which) begin
      a  = bus1.alu_select; im = bus1.imm; rd = bus1.rd; r1 = bus1.rs1; r2 = bus1.rs2;
      f3 = bus1.funct3_out;
      fl = {bus1.op_a_pc, bus1.op_b_imm, bus1.reg_write_en, bus1.mem_read,
            bus1.mem_write, bus1.branch, bus1.jump, bus1.illegal};
    end else begin
      a  = bus0.alu_select; im = bus0.imm; rd = bus0.rd; r1 = bus0.rs1; r2 = bus0.rs2;
      f3 = bus0.funct3_out;
      fl = {bus0.op_a_pc, bus0.op_b_imm, bus0.reg_write_en, bus0.mem_read,
            bus0.mem_write, bus0.branch, bus0.jump, bus0.illegal};
    end
    chk({tag, ".alu"}, 32'(a), 32'(e.alu));
    chk({tag, ".imm"}, im, e.imm);
    chk({tag, ".flags"}, 32'(fl), 32'(e.fl));
    chk({tag, ".rd"}, 32'(rd), 32'(ins[11:7]));
    chk({tag, ".rs1"}, 32'(r1), 32'(ins[19:15]));
    chk({tag, ".rs2"}, 32'(r2), 32'(ins[24:20]));
    chk({tag, ".funct3"}, 32'(f3), 32'(ins[14:12]));
  endtask

  task automatic drive(input logic iv, input logic [31:0] ins, input logic ordy,
                       input logic fl);
    bus1.in_valid  = iv;
    bus1.in_instr  = ins;
    bus1.out_ready = ordy;
    bus1.flush     = fl;
  endtask

  vec_t        vt[19];
  bit          mv;
  logic [31:0] mheld;
  logic [31:0] r_ins;
  logic        r_iv, r_ordy, r_fl, r_rdy;

  initial begin
    vt[0]  = '{32'h002081B3, '{6'b000000, 32'h00000000, F_WE}};
    vt[1]  = '{32'h402081B3, '{6'b010000, 32'h00000000, F_WE}};
    vt[2]  = '{32'h022081B3, '{6'b001000, 32'h00000000, F_WE}};
    vt[3]  = '{32'hFFF00093, '{6'b000000, 32'hFFFFFFFF, F_BIMM | F_WE}};
    vt[4]  = '{32'h123452B7, '{6'b011000, 32'h12345000, F_BIMM | F_WE}};
    vt[5]  = '{32'h0020A423, '{6'b000000, 32'h00000008, F_BIMM | F_MWR}};
    vt[6]  = '{32'hFFFFFFFF, '{6'b000000, 32'h00000000, F_ILL}};
    vt[7]  = '{32'h00208463, '{6'b010000, 32'h00000008, F_BR}};
    vt[8]  = '{32'hFE000EE3, '{6'b010000, 32'hFFFFFFFC, F_BR}};
    vt[9]  = '{32'h008000EF, '{6'b000000, 32'h00000008, F_APC | F_BIMM | F_WE | F_JMP}};
    vt[10] = '{32'hFFFFF117, '{6'b000000, 32'hFFFFF000, F_APC | F_BIMM | F_WE}};
    vt[11] = '{32'hFF812283, '{6'b000000, 32'hFFFFFFF8, F_BIMM | F_MRD | F_WE}};
    vt[12] = '{32'h4030D093, '{6'b010101, 32'h00000403, F_BIMM | F_WE}};
    vt[13] = '{32'h00000001, '{6'b000000, 32'h00000000, F_ILL}};
    vt[14] = '{32'h02009093, '{6'b000000, 32'h00000000, F_ILL}};
    vt[15] = '{32'h000010E7, '{6'b000000, 32'h00000000, F_ILL}};
    vt[16] = '{32'h0020C463, '{6'b000010, 32'h00000008, F_BR}};
    vt[17] = '{32'h0020F463, '{6'b000011, 32'h00000008, F_BR}};
    vt[18] = '{32'h0020A463, '{6'b000000, 32'h00000000, F_ILL}};

    // Reset with a valid word presented: nothing is captured
    rst = 1'b1;
    drive(1'b1, 32'h002081B3, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("reset.out_valid1", 32'(bus1.out_valid), 32'd0);
    chk("reset.out_valid0", 32'(bus0.out_valid), 32'd0);
    check_bundle("reset.b1", 1'b1, 32'h0, '0);
    check_bundle("reset.b0", 1'b0, 32'h0, '0);
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk("idle.out_valid", 32'(bus1.out_valid), 32'd0);

    // Vector table, applied back to back with the consumer always ready
    for (int i = 0; i < 19; i++) begin
      drive(1'b1, vt[i].ins, 1'b1, 1'b0);
      @(posedge clk); #1;
      chk($sformatf("vec%0d.out_valid", i), 32'(bus1.out_valid), 32'd1);
      check_bundle($sformatf("vec%0d.m1", i), 1'b1, vt[i].ins, vt[i].e);
      check_bundle($sformatf("vec%0d.m0", i), 1'b0, vt[i].ins, ref_decode(vt[i].ins, 1'b0));
      if (i == 2) chk("mul.no_mext_illegal", 32'(bus0.illegal), 32'd1);
    end

    // Store held for three cycles of back-pressure
    drive(1'b1, 32'h0020A423, 1'b1, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, 32'h002081B3, 1'b0, 1'b0);
    #1;
    chk("stall.in_ready", 32'(bus1.in_ready), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("stall%0d.in_ready", c), 32'(bus1.in_ready), 32'd0);
      chk($sformatf("stall%0d.out_valid", c), 32'(bus1.out_valid), 32'd1);
      check_bundle($sformatf("stall%0d", c), 1'b1, 32'h0020A423, vt[5].e);
    end
    bus1.out_ready = 1'b1;
    #1;
    chk("release.in_ready", 32'(bus1.in_ready), 32'd1);
    @(posedge clk); #1;
    chk("release.out_valid", 32'(bus1.out_valid), 32'd1);
    check_bundle("release", 1'b1, 32'h002081B3, vt[0].e);

    // Flush with a held bundle and a valid word presented
    drive(1'b1, 32'hFFF00093, 1'b1, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, 32'h123452B7, 1'b0, 1'b1);
    #1;
    chk("flush.in_ready", 32'(bus1.in_ready), 32'd0);
    @(posedge clk); #1;
    chk("flush.out_valid1", 32'(bus1.out_valid), 32'd0);
    chk("flush.out_valid0", 32'(bus0.out_valid), 32'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("flush.nothing_taken", 32'(bus1.out_valid), 32'd0);

    // Reset while stalled discards the held bundle
    drive(1'b1, 32'h123452B7, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("prerst.out_valid", 32'(bus1.out_valid), 32'd1);
    rst = 1'b1;
    drive(1'b1, 32'h002081B3, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("rststall.out_valid", 32'(bus1.out_valid), 32'd0);
    check_bundle("rststall", 1'b1, 32'h0, '0);
    rst = 1'b0;
    drive(1'b1, 32'h0020A423, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk("postrst.out_valid", 32'(bus1.out_valid), 32'd1);
    check_bundle("postrst", 1'b1, 32'h0020A423, vt[5].e);

    // Randomized traffic against the reference model
    mv    = 1'b1;
    mheld = 32'h0020A423;
    for (int n = 0; n < 400; n++) begin
      r_ins  = rand_instr();
      r_iv   = 1'($urandom_range(0, 1));
      r_ordy = ($urandom_range(0, 3) != 0);
      r_fl   = ($urandom_range(0, 15) == 0);
      drive(r_iv, r_ins, r_ordy, r_fl);
      #1;
      r_rdy = !r_fl && (!mv || r_ordy);
      chk("rnd.in_ready1", 32'(bus1.in_ready), 32'(r_rdy));
      chk("rnd.in_ready0", 32'(bus0.in_ready), 32'(r_rdy));
      @(posedge clk); #1;
      if (r_fl) begin
        mv = 1'b0;
      end else if (r_iv && r_rdy) begin
        mv    = 1'b1;
        mheld = r_ins;
      end else if (mv && r_ordy) begin
        mv = 1'b0;
      end
      chk("rnd.out_valid1", 32'(bus1.out_valid), 32'(mv));
      chk("rnd.out_valid0", 32'(bus0.out_valid), 32'(mv));
      if (mv) begin
        check_bundle($sformatf("rnd%0d.m1", n), 1'b1, mheld, ref_decode(mheld, 1'b1));
        check_bundle($sformatf("rnd%0d.m0", n), 1'b0, mheld, ref_decode(mheld, 1'b0));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
